// File: rtl/dt_scheduler.sv
// dt_scheduler: variable-timestep controller for the emulator models.
// Latency: requests sampled at edge n appear in dt/emu_time after edge n.
// Backpressure: none; run=0 pauses stepping, DONE holds until rst.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   dt_req/dt_req_valid packed per-requester timesteps and their valids
//   run                 level enable for stepping
//   stop_time           end time, latched when leaving IDLE
//   dt, emu_time        registered step and running sum of issued steps
//   step_count          saturating count of steps taken
//   running, done       registered state decodes
module dt_scheduler #(
  parameter int                   N_REQ       = 2,
  parameter int                   DT_WIDTH    = 25,
  parameter int                   TIME_WIDTH  = 40,
  parameter int                   CNT_WIDTH   = 32,
  parameter logic [DT_WIDTH-1:0]  DT_MAX      = {DT_WIDTH{1'b1}},
  // LSB weight is 2^DT_EXPONENT seconds; no arithmetic depends on it.
  parameter int                   DT_EXPONENT = -46
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          dt_req_valid,
  input  logic                      run,
  input  logic [TIME_WIDTH-1:0]     stop_time,
  output logic [DT_WIDTH-1:0]       dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic [CNT_WIDTH-1:0]      step_count,
  output logic                      running,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [TIME_WIDTH-1:0] stop_lat;

  logic [DT_WIDTH-1:0]   req_min;
  logic [DT_WIDTH-1:0]   dt_next;
  logic [TIME_WIDTH-1:0] remain;
  logic                  final_step;

  // Seeding the search with DT_MAX folds the clamp into the min tree and
  // also gives DT_MAX when no request is valid.
  always_comb begin
    req_min = DT_MAX;
    for (int k = 0; k < N_REQ; k++) begin
      if (dt_req_valid[k] && (dt_req[k*DT_WIDTH +: DT_WIDTH] < req_min)) begin
        req_min = dt_req[k*DT_WIDTH +: DT_WIDTH];
      end
    end
  end

  // stop_lat > emu_time whenever RUN is entered, so remain cannot wrap.
  // When truncating, remain <= dt step <= DT_MAX, so it fits in DT_WIDTH.
  always_comb begin
    remain     = stop_lat - emu_time;
    final_step = (TIME_WIDTH'(req_min) >= remain);
    dt_next    = final_step ? DT_WIDTH'(remain) : req_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stop_lat   <= '0;
      dt         <= '0;
      emu_time   <= '0;
      step_count <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dt <= '0;
          if (run) begin
            stop_lat <= stop_time;
            // Nothing left to do: finish without ever issuing a step.
            if (stop_time <= emu_time) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
              done    <= 1'b0;
            end
          end
        end

        RUN: begin
          if (!run) begin
            // Pause takes priority over a pending final step.
            state   <= IDLE;
            dt      <= '0;
            running <= 1'b0;
          end else begin
            dt       <= dt_next;
            emu_time <= emu_time + TIME_WIDTH'(dt_next);
            if (step_count != {CNT_WIDTH{1'b1}}) begin
              step_count <= step_count + CNT_WIDTH'(1);
            end
            if (final_step) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        DONE: begin
          dt      <= '0;
          running <= 1'b0;
          done    <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          dt      <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dt_scheduler.sv
module tb_dt_scheduler;

  localparam int N_REQ      = 2;
  localparam int DT_WIDTH   = 25;
  localparam int TIME_WIDTH = 40;
  localparam int CNT_WIDTH  = 32;
  localparam logic [DT_WIDTH-1:0] DT_MAX = 25'd500;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_REQ*DT_WIDTH-1:0] dt_req;
  logic [N_REQ-1:0]          dt_req_valid;
  logic                      run;
  logic [TIME_WIDTH-1:0]     stop_time;
  logic [DT_WIDTH-1:0]       dt;
  logic [TIME_WIDTH-1:0]     emu_time;
  logic [CNT_WIDTH-1:0]      step_count;
  logic                      running;
  logic                      done;

  int tests = 0;
  int fails = 0;

  dt_scheduler #(
    .N_REQ      (N_REQ),
    .DT_WIDTH   (DT_WIDTH),
    .TIME_WIDTH (TIME_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .DT_MAX     (DT_MAX),
    .DT_EXPONENT(-46)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dt_req      (dt_req),
    .dt_req_valid(dt_req_valid),
    .run         (run),
    .stop_time   (stop_time),
    .dt          (dt),
    .emu_time    (emu_time),
    .step_count  (step_count),
    .running     (running),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_dt, input int e_time,
                         input int e_cnt, input bit e_run, input bit e_done);
    chk({tag, ".dt"},         64'(dt),         64'(e_dt));
    chk({tag, ".emu_time"},   64'(emu_time),   64'(e_time));
    chk({tag, ".step_count"}, 64'(step_count), 64'(e_cnt));
    chk({tag, ".running"},    64'(running),    64'(e_run));
    chk({tag, ".done"},       64'(done),       64'(e_done));
  endtask

  task automatic set_req(input int r0, input int r1, input logic [1:0] v);
    dt_req       = {DT_WIDTH'(r1), DT_WIDTH'(r0)};
    dt_req_valid = v;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    stop_time = '0;
    set_req(0, 0, 2'b00);

    // Reset with random inputs on every edge.
    for (int i = 0; i < 3; i++) begin
      dt_req       = (N_REQ*DT_WIDTH)'({$urandom(), $urandom()});
      dt_req_valid = N_REQ'($urandom());
      run          = 1'($urandom());
      stop_time    = TIME_WIDTH'({$urandom(), $urandom()});
      tick();
      chk_all("reset", 0, 0, 0, 1'b0, 1'b0);
    end

    // Min over valid requests, invalid masking, empty set, clamp.
    rst = 1'b0;
    stop_time = 40'd2000;
    run = 1'b1;
    set_req(100, 40, 2'b11);
    tick(); chk_all("enter_run", 0, 0, 0, 1'b1, 1'b0);
    tick(); chk_all("min_1", 40, 40, 1, 1'b1, 1'b0);
    tick(); chk_all("min_2", 40, 80, 2, 1'b1, 1'b0);
    set_req(100, 40, 2'b01);
    tick(); chk_all("valid_01", 100, 180, 3, 1'b1, 1'b0);
    set_req(100, 40, 2'b00);
    tick(); chk_all("none_valid", 500, 680, 4, 1'b1, 1'b0);
    set_req(700, 40, 2'b01);
    tick(); chk_all("clamp", 500, 1180, 5, 1'b1, 1'b0);
    set_req(100, 600, 2'b10);
    tick(); chk_all("req1_only", 500, 1680, 6, 1'b1, 1'b0);

    // Truncation to stop, then DONE ignores run.
    rst = 1'b1; tick();
    chk_all("reset2", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    stop_time = 40'd250;
    set_req(100, 0, 2'b01);
    tick(); chk_all("trunc_enter", 0, 0, 0, 1'b1, 1'b0);
    tick(); chk_all("trunc_1", 100, 100, 1, 1'b1, 1'b0);
    tick(); chk_all("trunc_2", 100, 200, 2, 1'b1, 1'b0);
    tick(); chk_all("trunc_final", 50, 250, 3, 1'b0, 1'b1);
    tick(); chk_all("done_hold", 0, 250, 3, 1'b0, 1'b1);
    run = 1'b0;
    tick();
    run = 1'b1;
    stop_time = 40'd5000;
    tick(); chk_all("done_ignores_run", 0, 250, 3, 1'b0, 1'b1);

    // Pause, resume with new stop, pause priority over final step,
    // then stop not ahead of emu_time.
    rst = 1'b1; tick();
    chk_all("reset3", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    stop_time = 40'd1000;
    set_req(100, 40, 2'b11);
    tick(); chk_all("p_enter", 0, 0, 0, 1'b1, 1'b0);
    tick(); chk_all("p_step1", 40, 40, 1, 1'b1, 1'b0);
    tick(); chk_all("p_step2", 40, 80, 2, 1'b1, 1'b0);
    run = 1'b0;
    tick(); chk_all("pause", 0, 80, 2, 1'b0, 1'b0);
    tick(); chk_all("pause_hold", 0, 80, 2, 1'b0, 1'b0);
    stop_time = 40'd200;
    run = 1'b1;
    tick(); chk_all("resume_enter", 0, 80, 2, 1'b1, 1'b0);
    stop_time = 40'd9999;  // must not affect the latched stop
    tick(); chk_all("resume_1", 40, 120, 3, 1'b1, 1'b0);
    tick(); chk_all("resume_2", 40, 160, 4, 1'b1, 1'b0);
    // remain is now 40, so this would be the final step; pause wins.
    run = 1'b0;
    tick(); chk_all("pause_prio", 0, 160, 4, 1'b0, 1'b0);
    stop_time = 40'd160;
    run = 1'b1;
    tick(); chk_all("stop_not_ahead", 0, 160, 4, 1'b0, 1'b1);

    // Zero-length steps are counted; mid-RUN reset clears everything.
    rst = 1'b1; tick();
    chk_all("reset4", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    stop_time = 40'd1000;
    set_req(0, 40, 2'b10);
    tick(); chk_all("z_enter", 0, 0, 0, 1'b1, 1'b0);
    tick(); chk_all("z_first", 40, 40, 1, 1'b1, 1'b0);
    set_req(0, 40, 2'b11);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_all("zero_step", 0, 40, 2 + i, 1'b1, 1'b0);
    end
    set_req(0, 40, 2'b10);
    tick(); chk_all("z_after", 40, 80, 6, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk_all("mid_run_reset", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    run = 1'b0;
    tick(); chk_all("post_reset_idle", 0, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
